// File: rtl/noc_vc_fifo.sv
// Multi-virtual-channel flit buffer: NUM_VC independent circular queues of DEPTH flits,
// registered one-cycle read with valid strobe, per-VC status and sticky error flags.
module noc_vc_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int NUM_VC    = 2,
    parameter int AF_THRESH = 3,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    err_ovf,
    output logic                    err_udf
);

    localparam logic [VC_W:0]  NUM_VC_L = (VC_W + 1)'(NUM_VC);
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_L    = CNT_W'(AF_THRESH);

    logic [DATA_W-1:0]             mem_r [NUM_VC][DEPTH];
    logic [NUM_VC-1:0][PTR_W-1:0]  wptr_r;
    logic [NUM_VC-1:0][PTR_W-1:0]  rptr_r;
    logic [NUM_VC-1:0][CNT_W-1:0]  cnt_r;
    logic [NUM_VC-1:0][CNT_W-1:0]  cnt_nxt_s;
    logic [NUM_VC-1:0]             inc_s;
    logic [NUM_VC-1:0]             dec_s;
    logic                          wr_acc_s;
    logic                          rd_acc_s;

    assign count = cnt_r;

    // Accept decisions; out-of-range VCs are never accepted and there is no write-to-read bypass.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (wr_en && ({1'b0, wr_vc} < NUM_VC_L)) begin
            wr_acc_s = ~full[wr_vc];
        end else begin
            wr_acc_s = 1'b0;
        end
        if (rd_en && ({1'b0, rd_vc} < NUM_VC_L)) begin
            rd_acc_s = ~empty[rd_vc];
        end else begin
            rd_acc_s = 1'b0;
        end
    end

    // Next occupancy per VC; a same-VC write and read cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        inc_s     = {NUM_VC{1'b0}};
        dec_s     = {NUM_VC{1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            inc_s[v] = wr_acc_s && (wr_vc == VC_W'(v));
            dec_s[v] = rd_acc_s && (rd_vc == VC_W'(v));
            case ({inc_s[v], dec_s[v]})
                2'b10:   cnt_nxt_s[v] = cnt_r[v] + CNT_W'(1);
                2'b01:   cnt_nxt_s[v] = cnt_r[v] - CNT_W'(1);
                default: cnt_nxt_s[v] = cnt_r[v];
            endcase
        end
    end

    // Flit storage, deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_r[wr_vc][wptr_r[wr_vc]] <= wr_data;
        end
    end

    // Pointers, counts, flags, read port and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            cnt_r       <= '0;
            full        <= {NUM_VC{1'b0}};
            empty       <= {NUM_VC{1'b1}};
            almost_full <= {NUM_VC{1'b0}};
            rd_data     <= {DATA_W{1'b0}};
            rd_valid    <= 1'b0;
            err_ovf     <= 1'b0;
            err_udf     <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            for (int v = 0; v < NUM_VC; v++) begin
                full[v]        <= (cnt_nxt_s[v] == DEPTH_L);
                empty[v]       <= (cnt_nxt_s[v] == CNT_W'(0));
                almost_full[v] <= (cnt_nxt_s[v] >= AF_L);
            end
            if (wr_acc_s) begin
                wptr_r[wr_vc] <= wptr_r[wr_vc] + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rptr_r[rd_vc] <= rptr_r[rd_vc] + PTR_W'(1);
                rd_data       <= mem_r[rd_vc][rptr_r[rd_vc]];
                rd_valid      <= 1'b1;
            end else begin
                rd_valid      <= 1'b0;
            end
            err_ovf <= err_ovf | (wr_en & ~wr_acc_s);
            err_udf <= err_udf | (rd_en & ~rd_acc_s);
        end
    end

endmodule
